fp_adder_driver: RTL and testbench

AXI-stream initiator for the floating-point adder. It takes operand pairs from a simple valid/ready push port and buffers them. It drives them onto the adder's two independent operand channels (A, B), then collects the adder's result stream into a result buffer that is drained through a valid/ready pop port. Credit-based issue ensures every result the adder produces always has buffer space, so the adder's result channel is never back-pressured by a full buffer.

---
 rtl/fp_stream_pkg.sv | 14 +
 rtl/sync_fifo.sv | 55 +++++
 rtl/fp_adder_driver.sv | 148 ++++++++++++++
 tb/tb_fp_adder_driver.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_stream_pkg.sv
// Shared types and defaults for the floating-point adder stream driver.
package fp_stream_pkg;

   localparam int DATA_W_DEF    = 32;
   localparam int RES_DEPTH_DEF = 8;

   typedef struct packed {
      logic [DATA_W_DEF-1:0] a;
      logic [DATA_W_DEF-1:0] b;
   } op_pair_t;

   typedef logic [$clog2(RES_DEPTH_DEF):0] inflight_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers; used for operand pairs and results.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         data_i,
   output logic [WIDTH-1:0]         data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_push, do_pop;

   // The extra top pointer bit tells a full FIFO from an empty one after wrap.
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign count_o = wr_ptr_q - rd_ptr_q;
   assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
   end

endmodule

// File: rtl/fp_adder_driver.sv
// Feeds buffered operand pairs to an adder over two AXI-stream channels and
// collects its results, issuing only when the result buffer has a slot reserved.
module fp_adder_driver
   import fp_stream_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int OP_DEPTH  = 4,
   parameter int RES_DEPTH = RES_DEPTH_DEF
) (
   input  logic                        i_clk,
   input  logic                        aresetn,
   input  logic                        op_valid,
   output logic                        op_ready,
   input  logic [DATA_W-1:0]           op_a,
   input  logic [DATA_W-1:0]           op_b,
   output logic                        m_axis_a_tvalid,
   input  logic                        m_axis_a_tready,
   output logic [DATA_W-1:0]           m_axis_a_tdata,
   output logic                        m_axis_b_tvalid,
   input  logic                        m_axis_b_tready,
   output logic [DATA_W-1:0]           m_axis_b_tdata,
   input  logic                        s_axis_result_tvalid,
   output logic                        s_axis_result_tready,
   input  logic [DATA_W-1:0]           s_axis_result_tdata,
   output logic                        res_valid,
   input  logic                        res_ready,
   output logic [DATA_W-1:0]           res_data,
   output logic [$clog2(RES_DEPTH):0]  inflight,
   output logic                        idle,
   output logic                        err_unexpected
);

   localparam int CW  = $clog2(RES_DEPTH) + 1;
   localparam int OCW = $clog2(OP_DEPTH) + 1;

   // Handshake rule on every port: a transfer happens on the rising edge where
   // valid and ready are both high; a raised valid holds, with stable data,
   // until that transfer.

   logic                  op_full, op_empty, op_push, op_pop;
   logic [2*DATA_W-1:0]   op_head;
   logic [OCW-1:0]        op_count;
   logic                  res_full, res_empty, res_push, res_pop;
   logic [CW-1:0]         res_count;

   logic                  a_sent_q, a_sent_d;
   logic                  b_sent_q, b_sent_d;
   logic [CW-1:0]         inflight_q, inflight_d;
   logic                  err_q, err_d;

   logic [CW:0]           credit_used;
   logic                  credit_ok, start_ok;
   logic                  a_hs, b_hs, pair_done, unexpected;

   sync_fifo #(
      .WIDTH (2*DATA_W),
      .DEPTH (OP_DEPTH)
   ) u_op_fifo (
      .clk_i   (i_clk),
      .rst_ni  (aresetn),
      .push_i  (op_push),
      .pop_i   (op_pop),
      .data_i  ({op_a, op_b}),
      .data_o  (op_head),
      .full_o  (op_full),
      .empty_o (op_empty),
      .count_o (op_count)
   );

   sync_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (RES_DEPTH)
   ) u_res_fifo (
      .clk_i   (i_clk),
      .rst_ni  (aresetn),
      .push_i  (res_push),
      .pop_i   (res_pop),
      .data_i  (s_axis_result_tdata),
      .data_o  (res_data),
      .full_o  (res_full),
      .empty_o (res_empty),
      .count_o (res_count)
   );

   assign op_ready = aresetn && !op_full;
   assign op_push  = op_valid && op_ready;

   // A new pair may start only if its result already has a reserved slot;
   // a half-sent pair is always allowed to finish.
   assign credit_used = {1'b0, inflight_q} + {1'b0, res_count};
   assign credit_ok   = credit_used < (CW+1)'(RES_DEPTH);
   assign start_ok    = a_sent_q || b_sent_q || credit_ok;

   assign m_axis_a_tvalid = !op_empty && !a_sent_q && start_ok;
   assign m_axis_b_tvalid = !op_empty && !b_sent_q && start_ok;
   assign m_axis_a_tdata  = op_head[2*DATA_W-1:DATA_W];
   assign m_axis_b_tdata  = op_head[DATA_W-1:0];

   assign a_hs      = m_axis_a_tvalid && m_axis_a_tready;
   assign b_hs      = m_axis_b_tvalid && m_axis_b_tready;
   assign pair_done = !op_empty && (a_sent_q || a_hs) && (b_sent_q || b_hs);
   assign op_pop    = pair_done;

   assign s_axis_result_tready = aresetn && !res_full;
   assign res_push   = s_axis_result_tvalid && s_axis_result_tready;
   assign unexpected = res_push && (inflight_q == '0);
   assign res_valid  = !res_empty;
   assign res_pop    = res_valid && res_ready;

   always_comb begin
      a_sent_d   = a_sent_q;
      b_sent_d   = b_sent_q;
      inflight_d = inflight_q;
      err_d      = err_q || unexpected;
      if (pair_done) begin
         a_sent_d = 1'b0;
         b_sent_d = 1'b0;
      end else begin
         a_sent_d = a_sent_q || a_hs;
         b_sent_d = b_sent_q || b_hs;
      end
      // A result with nothing outstanding is stored but not counted.
      case ({pair_done, res_push && !unexpected})
         2'b10:   inflight_d = inflight_q + CW'(1);
         2'b01:   inflight_d = inflight_q - CW'(1);
         default: inflight_d = inflight_q;
      endcase
   end

   always_ff @(posedge i_clk or negedge aresetn) begin
      if (!aresetn) begin
         a_sent_q   <= 1'b0;
         b_sent_q   <= 1'b0;
         inflight_q <= '0;
         err_q      <= 1'b0;
      end else begin
         a_sent_q   <= a_sent_d;
         b_sent_q   <= b_sent_d;
         inflight_q <= inflight_d;
         err_q      <= err_d;
      end
   end

   assign inflight       = inflight_q;
   assign err_unexpected = err_q;
   assign idle           = (op_count == '0) && res_empty && (inflight_q == '0);

endmodule

// File: tb/tb_fp_adder_driver.sv
// Randomized and directed bench for fp_adder_driver with a stub adder and an
// occupancy-level reference model.
module tb_fp_adder_driver;
   import fp_stream_pkg::*;

   localparam int OP_DEPTH  = 4;
   localparam int RES_DEPTH = 8;

   logic        i_clk = 1'b0;
   logic        aresetn = 1'b0;
   logic        op_valid = 1'b0;
   logic        op_ready;
   logic [31:0] op_a = '0, op_b = '0;
   logic        m_axis_a_tvalid, m_axis_b_tvalid;
   logic        m_axis_a_tready = 1'b0, m_axis_b_tready = 1'b0;
   logic [31:0] m_axis_a_tdata, m_axis_b_tdata;
   logic        s_axis_result_tvalid = 1'b0;
   logic        s_axis_result_tready;
   logic [31:0] s_axis_result_tdata = '0;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [31:0] res_data;
   inflight_t   inflight;
   logic        idle, err_unexpected;

   fp_adder_driver #(.DATA_W(32), .OP_DEPTH(OP_DEPTH), .RES_DEPTH(RES_DEPTH)) dut (
      .i_clk                (i_clk),
      .aresetn              (aresetn),
      .op_valid             (op_valid),
      .op_ready             (op_ready),
      .op_a                 (op_a),
      .op_b                 (op_b),
      .m_axis_a_tvalid      (m_axis_a_tvalid),
      .m_axis_a_tready      (m_axis_a_tready),
      .m_axis_a_tdata       (m_axis_a_tdata),
      .m_axis_b_tvalid      (m_axis_b_tvalid),
      .m_axis_b_tready      (m_axis_b_tready),
      .m_axis_b_tdata       (m_axis_b_tdata),
      .s_axis_result_tvalid (s_axis_result_tvalid),
      .s_axis_result_tready (s_axis_result_tready),
      .s_axis_result_tdata  (s_axis_result_tdata),
      .res_valid            (res_valid),
      .res_ready            (res_ready),
      .res_data             (res_data),
      .inflight             (inflight),
      .idle                 (idle),
      .err_unexpected       (err_unexpected)
   );

   // ---------------- clock ----------------
   always #5 i_clk = ~i_clk;

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   // ---------------- checking ----------------
   int checks = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Integer-valued floats keep the stub adder exact.
   function automatic logic [31:0] int_to_fp(input int unsigned v);
      int e;
      logic [31:0] m;
      e = 0;
      if (v == 0) return 32'h0;
      for (int i = 0; i < 24; i++) if (v[i]) e = i;
      m = v << (23 - e);
      return {1'b0, 8'(127 + e), m[22:0]};
   endfunction

   function automatic int unsigned fp_to_int(input logic [31:0] f);
      int e;
      logic [31:0] m;
      if (f[30:0] == 31'h0) return 0;
      e = int'(f[30:23]) - 127;
      m = {8'h0, 1'b1, f[22:0]};
      return m >> (23 - e);
   endfunction

   // ---------------- reference model / scoreboard ----------------
   logic [31:0] exp_a_q[$], exp_b_q[$], exp_q[$];
   logic [31:0] add_a_q[$], add_b_q[$], pend_data[$];
   int          pend_due[$];
   int          add_lat = 1;
   int          last_due = 0;
   int          n_push = 0, na = 0, nb = 0, n_acc = 0, n_pop = 0, n_unexp = 0;
   int          inflight_m = 0;
   bit          err_m = 0;
   bit          a_pend = 0, b_pend = 0;
   logic [31:0] a_prev, b_prev;

   always @(negedge i_clk) begin : monitor
      int occ_op, occ_res, iss_old, iss_new, started, due;
      bit unexp, res_hs;
      if (!aresetn) begin
         a_pend = 0;
         b_pend = 0;
      end else begin
         iss_old = (na < nb) ? na : nb;
         started = (na > nb) ? na : nb;
         occ_op  = n_push - iss_old;
         occ_res = n_acc - n_pop;
         check_eq("inflight", 32'(inflight), 32'(inflight_m));
         check_eq("err_unexpected", 32'(err_unexpected), 32'(err_m));
         check_eq("idle", 32'(idle), 32'(occ_op == 0 && occ_res == 0 && inflight_m == 0));
         check_eq("op_ready", 32'(op_ready), 32'(occ_op < OP_DEPTH));
         check_eq("res_valid", 32'(res_valid), 32'(occ_res > 0));
         check_eq("result_tready", 32'(s_axis_result_tready), 32'(occ_res < RES_DEPTH));
         check_eq("credit_bound", 32'(started - n_pop + n_unexp <= RES_DEPTH), 32'd1);
         if (a_pend) begin
            check_eq("a_hold_valid", 32'(m_axis_a_tvalid), 32'd1);
            check_eq("a_hold_data", m_axis_a_tdata, a_prev);
         end
         if (b_pend) begin
            check_eq("b_hold_valid", 32'(m_axis_b_tvalid), 32'd1);
            check_eq("b_hold_data", m_axis_b_tdata, b_prev);
         end
         a_pend = m_axis_a_tvalid && !m_axis_a_tready;
         b_pend = m_axis_b_tvalid && !m_axis_b_tready;
         a_prev = m_axis_a_tdata;
         b_prev = m_axis_b_tdata;

         if (op_valid && op_ready) begin
            exp_a_q.push_back(op_a);
            exp_b_q.push_back(op_b);
            exp_q.push_back(int_to_fp(fp_to_int(op_a) + fp_to_int(op_b)));
            n_push++;
         end
         if (m_axis_a_tvalid && m_axis_a_tready) begin
            check_eq("a_order_avail", 32'(exp_a_q.size() > 0), 32'd1);
            if (exp_a_q.size() > 0) check_eq("a_data", m_axis_a_tdata, exp_a_q.pop_front());
            add_a_q.push_back(m_axis_a_tdata);
            na++;
         end
         if (m_axis_b_tvalid && m_axis_b_tready) begin
            check_eq("b_order_avail", 32'(exp_b_q.size() > 0), 32'd1);
            if (exp_b_q.size() > 0) check_eq("b_data", m_axis_b_tdata, exp_b_q.pop_front());
            add_b_q.push_back(m_axis_b_tdata);
            nb++;
         end
         while (add_a_q.size() > 0 && add_b_q.size() > 0) begin
            due = cyc + add_lat;
            if (due < last_due) due = last_due;
            last_due = due;
            pend_data.push_back(int_to_fp(fp_to_int(add_a_q.pop_front()) +
                                          fp_to_int(add_b_q.pop_front())));
            pend_due.push_back(due);
         end
         res_hs = s_axis_result_tvalid && s_axis_result_tready;
         unexp  = res_hs && (inflight_m == 0);
         if (res_hs) begin
            n_acc++;
            if (pend_data.size() > 0) begin
               void'(pend_data.pop_front());
               void'(pend_due.pop_front());
            end
         end
         if (unexp) begin
            n_unexp++;
            err_m = 1;
         end
         iss_new = (na < nb) ? na : nb;
         inflight_m = inflight_m + (iss_new - iss_old) - ((res_hs && !unexp) ? 1 : 0);
         if (res_valid && res_ready) begin
            check_eq("res_order_avail", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check_eq("res_data", res_data, exp_q.pop_front());
            n_pop++;
         end
      end
   end

   // Stub adder: presents each result once its latency has elapsed.
   always @(posedge i_clk) begin
      #1;
      if (!aresetn || pend_data.size() == 0) begin
         s_axis_result_tvalid = 1'b0;
      end else if (pend_due[0] <= cyc) begin
         s_axis_result_tvalid = 1'b1;
         s_axis_result_tdata  = pend_data[0];
      end else begin
         s_axis_result_tvalid = 1'b0;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge i_clk);
         #1;
      end
   endtask

   task automatic push_pair(input int unsigned a, input int unsigned b);
      bit taken;
      taken = 0;
      op_valid = 1'b1;
      op_a = int_to_fp(a);
      op_b = int_to_fp(b);
      for (int i = 0; i < 200 && !taken; i++) begin
         @(negedge i_clk);
         taken = op_ready;
         @(posedge i_clk);
         #1;
      end
      op_valid = 1'b0;
      check_eq("push_accept", 32'(taken), 32'd1);
   endtask

   task automatic inject(input logic [31:0] v);
      pend_data.push_back(v);
      pend_due.push_back(cyc);
      exp_q.push_back(v);
   endtask

   task automatic wait_drain(input string tag);
      bit done;
      done = 0;
      for (int i = 0; i < 600 && !done; i++) begin
         tick();
         done = (exp_q.size() == 0) && (pend_data.size() == 0) && idle && !s_axis_result_tvalid;
      end
      check_eq(tag, 32'(done), 32'd1);
   endtask

   task automatic reset_model();
      exp_a_q.delete(); exp_b_q.delete(); exp_q.delete();
      add_a_q.delete(); add_b_q.delete();
      pend_data.delete(); pend_due.delete();
      n_push = 0; na = 0; nb = 0; n_acc = 0; n_pop = 0; n_unexp = 0;
      inflight_m = 0; err_m = 0; last_due = 0;
      a_pend = 0; b_pend = 0;
   endtask

   task automatic check_reset_values(input string tag);
      check_eq({tag, "_op_ready"}, 32'(op_ready), 32'd0);
      check_eq({tag, "_a_tvalid"}, 32'(m_axis_a_tvalid), 32'd0);
      check_eq({tag, "_b_tvalid"}, 32'(m_axis_b_tvalid), 32'd0);
      check_eq({tag, "_res_tready"}, 32'(s_axis_result_tready), 32'd0);
      check_eq({tag, "_res_valid"}, 32'(res_valid), 32'd0);
      check_eq({tag, "_inflight"}, 32'(inflight), 32'd0);
      check_eq({tag, "_idle"}, 32'(idle), 32'd1);
      check_eq({tag, "_err"}, 32'(err_unexpected), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int base;
      #2;
      check_reset_values("por");
      tick(3);
      aresetn = 1'b1;
      tick(2);
      check_eq("op_ready_after_reset", 32'(op_ready), 32'd1);
      check_eq("res_tready_after_reset", 32'(s_axis_result_tready), 32'd1);

      // Single pair: 1.0 + 2.0
      m_axis_a_tready = 1'b1; m_axis_b_tready = 1'b1; res_ready = 1'b0; add_lat = 1;
      push_pair(1, 2);
      check_eq("single_a_tvalid", 32'(m_axis_a_tvalid), 32'd1);
      check_eq("single_b_tvalid", 32'(m_axis_b_tvalid), 32'd1);
      check_eq("single_a_tdata", m_axis_a_tdata, 32'h3F80_0000);
      check_eq("single_b_tdata", m_axis_b_tdata, 32'h4000_0000);
      tick(4);
      check_eq("single_res_valid", 32'(res_valid), 32'd1);
      check_eq("single_res_data", res_data, 32'h4040_0000);
      check_eq("single_inflight", 32'(inflight), 32'd0);
      res_ready = 1'b1;
      tick(2);
      check_eq("single_idle", 32'(idle), 32'd1);

      // Skewed channels: B stalled for three cycles
      m_axis_b_tready = 1'b0;
      push_pair(10, 20);
      push_pair(30, 40);
      check_eq("skew_a_dropped", 32'(m_axis_a_tvalid), 32'd0);
      check_eq("skew_b_waiting", 32'(m_axis_b_tvalid), 32'd1);
      check_eq("skew_b_tdata", m_axis_b_tdata, int_to_fp(20));
      tick(2);
      check_eq("skew_a_still_low", 32'(m_axis_a_tvalid), 32'd0);
      m_axis_b_tready = 1'b1;
      m_axis_a_tready = 1'b0;
      tick();
      check_eq("skew_next_a_tvalid", 32'(m_axis_a_tvalid), 32'd1);
      check_eq("skew_next_b_tvalid", 32'(m_axis_b_tvalid), 32'd1);
      check_eq("skew_next_a_tdata", m_axis_a_tdata, int_to_fp(30));
      check_eq("skew_next_b_tdata", m_axis_b_tdata, int_to_fp(40));
      m_axis_a_tready = 1'b1;
      wait_drain("skew_drain");

      // Operand FIFO full with A stalled; extra push must be refused
      m_axis_a_tready = 1'b0;
      for (int i = 0; i < OP_DEPTH; i++) push_pair(101 + i, 201 + i);
      check_eq("full_op_ready", 32'(op_ready), 32'd0);
      check_eq("full_a_tvalid", 32'(m_axis_a_tvalid), 32'd1);
      check_eq("full_b_sent", 32'(m_axis_b_tvalid), 32'd0);
      op_valid = 1'b1; op_a = int_to_fp(999); op_b = int_to_fp(999);
      tick();
      op_valid = 1'b0;
      check_eq("full_still_full", 32'(op_ready), 32'd0);
      m_axis_a_tready = 1'b1;
      wait_drain("full_drain");

      // Credit stall: results held, adder latency 5
      res_ready = 1'b0; add_lat = 5;
      base = na;
      for (int i = 0; i < 12; i++) push_pair($urandom_range(1, 1000), $urandom_range(1, 1000));
      tick(20);
      check_eq("credit_a_issued", 32'(na - base), 32'd8);
      check_eq("credit_b_issued", 32'(nb - base), 32'd8);
      check_eq("credit_a_stalled", 32'(m_axis_a_tvalid), 32'd0);
      check_eq("credit_b_stalled", 32'(m_axis_b_tvalid), 32'd0);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      tick(10);
      check_eq("credit_one_more_a", 32'(na - base), 32'd9);
      check_eq("credit_one_more_b", 32'(nb - base), 32'd9);
      res_ready = 1'b1;
      wait_drain("credit_drain");

      // Randomized traffic
      for (int i = 0; i < 500; i++) begin
         op_valid        = 1'($urandom_range(0, 1));
         op_a            = int_to_fp($urandom_range(1, 1000));
         op_b            = int_to_fp($urandom_range(1, 1000));
         m_axis_a_tready = ($urandom_range(0, 3) != 0);
         m_axis_b_tready = ($urandom_range(0, 3) != 0);
         res_ready       = ($urandom_range(0, 3) != 0);
         add_lat         = $urandom_range(1, 6);
         tick();
      end
      op_valid = 1'b0; m_axis_a_tready = 1'b1; m_axis_b_tready = 1'b1; res_ready = 1'b1;
      wait_drain("random_drain");

      // Unexpected result at idle
      res_ready = 1'b0;
      check_eq("unexp_idle_before", 32'(idle), 32'd1);
      inject(32'hDEAD_BEEF);
      tick(3);
      check_eq("unexp_res_valid", 32'(res_valid), 32'd1);
      check_eq("unexp_res_data", res_data, 32'hDEAD_BEEF);
      check_eq("unexp_inflight", 32'(inflight), 32'd0);
      check_eq("unexp_err", 32'(err_unexpected), 32'd1);
      res_ready = 1'b1;
      tick(3);
      check_eq("unexp_err_sticky", 32'(err_unexpected), 32'd1);
      check_eq("unexp_popped", 32'(res_valid), 32'd0);

      // Reset mid-stream: 2 in flight, 3 queued
      res_ready = 1'b0; add_lat = 40;
      push_pair(5, 6);
      push_pair(7, 8);
      tick(3);
      m_axis_a_tready = 1'b0; m_axis_b_tready = 1'b0;
      for (int i = 0; i < 3; i++) push_pair(50 + i, 60 + i);
      tick();
      check_eq("mid_inflight", 32'(inflight), 32'd2);
      #2;
      aresetn = 1'b0;
      #1;
      check_reset_values("mid");
      reset_model();
      tick(2);
      aresetn = 1'b1;
      m_axis_a_tready = 1'b1; m_axis_b_tready = 1'b1; res_ready = 1'b1;
      tick(60);
      check_eq("mid_no_residual", 32'(res_valid), 32'd0);
      check_eq("mid_idle", 32'(idle), 32'd1);
      check_eq("mid_no_results", 32'(n_acc), 32'd0);
      check_eq("mid_no_issue", 32'(na + nb), 32'd0);

      check_eq("exp_left", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
